spike_mac_scheduler: RTL and testbench
======================================

// Module: spike_mac_scheduler
// PURPOSE
//  Shares one simp_pipe_spike_MAC_builtin instance (fixed 2-cycle latency, no stall) between NUM_REQ spike sources.
//  Round-robin arbitration; issues at most one spike vector per cycle; tracks requester IDs through the MAC pipeline.
//  Returns each result tagged with its requester ID through a valid/ready result port backed by a credit-checked FIFO.
//  Sits between the spike generators and the MAC. The weight matrix is wired to the MAC at top level, not here.
// PARAMETERS
//  NUM_REQ    4  number of requesters, >=2
//  RES_DEPTH  4  result FIFO entries; must be >= MAC_LAT+2 for one result per cycle
//  INPUT_VEC_LEN, OUTPUT_VEC_LEN, WIDTH  from DPE_params; MAC shape
// PORTS
//  clk         in   1                        clock
//  rst_n       in   1                        synchronous active-low reset, shared with the MAC
//  req_valid   in   NUM_REQ                  per-requester spike vector valid
//  req_spikes  in   NUM_REQ x INPUT_VEC_LEN  per-requester spike vectors
//  req_ready   out  NUM_REQ                  one-hot grant; transfer when valid&ready
//  mac_spikes  out  INPUT_VEC_LEN            to MAC spikes input; all zero when not issuing
//  mac_out     in   OUTPUT_VEC_LEN x WIDTH   from MAC out
//  res_valid   out  1                        result available
//  res_ready   in   1                        consumer accepts result
//  res_data    out  OUTPUT_VEC_LEN x WIDTH   MAC result, bit-exact
//  res_id      out  ID_W=$clog2(NUM_REQ)     requester that issued the vector
//  busy        out  1                        any op in flight or FIFO non-empty
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): RR pointer=0, in-flight tags cleared, FIFO emptied.
//   res_valid=0, res_data=0, res_id=0, busy=0. req_ready=0 and mac_spikes=0 while rst_n=0.
//  Credit: issue allowed iff fifo_count + inflight_count < RES_DEPTH. Both use registered values.
//   A pop in the current cycle does not add credit until the next cycle. The FIFO can never overflow.
//  Arbitration: scan req_valid starting at ptr, wrapping modulo NUM_REQ. First valid wins.
//   If credit is allowed, req_ready[win]=1 and all other ready bits are 0 (combinational from valid, ptr and counts).
//   On issue, ptr <= win+1 (wraps). With no issue, ptr holds.
//  Issue cycle T: mac_spikes = req_spikes[win] combinationally. The tag pipeline captures {1, win}.
//   mac_out for this op is valid in cycle T+2 (MAC_LAT=2).
//   Tag stage 2 valid in T+2 pushes {mac_out, id} into the FIFO at the T+2->T+3 edge.
//  Tag pipeline: 2-stage shift of {vld, id}, advancing every cycle. Bubbles are inserted when nothing is issued.
//   inflight_count = popcount of stage valids.
//  FIFO: res_valid = !empty. Pop on res_valid&res_ready. Push and pop in the same cycle leave the count unchanged.
//   res_data/res_id hold stable while res_valid&!res_ready. Results are delivered in issue order.
//  An all-zero spike vector is a legal op and produces a result (all zeros from the MAC).
//  Throughput: one issue per cycle sustained when res_ready=1 and RES_DEPTH>=4.
//  Reset mid-operation: in-flight ops and FIFO contents are discarded. The MAC is reset by the same rst_n, so there are no stale results.
//  busy = |tag_vld | (fifo_count!=0).
// STRUCTURE
//  DPE_params additions: localparam MAC_LAT=2; typedef spike_vec_t [INPUT_VEC_LEN-1:0]; typedef mac_res_t [OUTPUT_VEC_LEN-1:0][WIDTH-1:0].
//  Sub-module: spike_mac_res_fifo (synchronous FIFO, DEPTH param, payload {mac_res_t, id}, count output).
//  Arbiter, credit check and tag pipeline stay inline. The MAC is instantiated next to this block at top level.
// TESTING (bench: NUM_REQ=4, INPUT_VEC_LEN=4, OUTPUT_VEC_LEN=2, WIDTH=8, matrix row0={1,2,3,4}, row1={10,20,30,40})
//  Single op: req1 spikes=4'b0101, res_ready=1 -> req_ready=4'b0010 at T; res_valid at T+3, res_data={40,4}, res_id=1.
//   (Element i of the vector gates column i: row0 sums columns 0,2 = 1+3; row1 = 10+30.)
//  RR fairness: all 4 valid for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. Results arrive in the same ID order with no gaps.
//  Backpressure: all valid, res_ready=0 -> exactly 4 issues, then req_ready=0. FIFO is full with the 4 results.
//   Release res_ready -> results drain in order and issue resumes.
//  Simultaneous push/pop with FIFO at 3 entries and 1 in flight -> count stays 3. No overflow and no lost result.
//  Zero vector: req2 spikes=0 -> result {0,0} with res_id=2.
//  Reset mid-op: 2 ops in flight, 2 in FIFO, pulse rst_n low 1 cycle -> res_valid=0, busy=0.
//   No result appears for the flushed ops. Next op returns the correct value with ptr restarted at 0.

Source files
------------

// File: rtl/spike_mac_scheduler_pkg.sv
// Shared shapes for the spike MAC scheduler: MAC vector geometry, pipeline latency and payload types.
package spike_mac_scheduler_pkg;

  localparam int INPUT_VEC_LEN  = 4;
  localparam int OUTPUT_VEC_LEN = 2;
  localparam int WIDTH          = 8;
  localparam int MAC_LAT        = 2;

  typedef logic [INPUT_VEC_LEN-1:0] spike_vec_t;
  typedef logic [OUTPUT_VEC_LEN-1:0][WIDTH-1:0] mac_res_t;

endpackage

// File: rtl/spike_mac_res_fifo.sv
// Result FIFO holding tagged MAC results until the consumer takes them.
module spike_mac_res_fifo
  import spike_mac_scheduler_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  ID_W  = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  mac_res_t        push_data,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            valid,
  output mac_res_t        data,
  output logic [ID_W-1:0] id,
  output logic [CW-1:0]   count
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  mac_res_t        mem_data [DEPTH];
  logic [ID_W-1:0] mem_id   [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= push_data;
      mem_id[wr_ptr]   <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Outputs read as zero when empty so the reset value is well defined.
  assign data = valid ? mem_data[rd_ptr] : '0;
  assign id   = valid ? mem_id[rd_ptr]   : '0;

endmodule

// File: rtl/spike_mac_scheduler.sv
// Round-robin scheduler sharing one fixed-latency spike MAC between NUM_REQ sources,
// tracking requester IDs through the MAC and returning tagged results through a FIFO.
module spike_mac_scheduler
  import spike_mac_scheduler_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  RES_DEPTH = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic       [NUM_REQ-1:0] req_valid,
  input  spike_vec_t [NUM_REQ-1:0] req_spikes,
  output logic       [NUM_REQ-1:0] req_ready,
  output spike_vec_t               mac_spikes,
  input  mac_res_t                 mac_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output mac_res_t                 res_data,
  output logic       [ID_W-1:0]    res_id,
  output logic                     busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int IW = $clog2(MAC_LAT + 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [OW-1:0]   DEPTH_OCC = OW'(RES_DEPTH);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic               found;
  int                 cand;
  logic               credit;
  logic               issue;
  logic [MAC_LAT-1:0] tag_vld;
  logic [ID_W-1:0]    tag_id [MAC_LAT];
  logic [IW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [OW-1:0]      occ;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MAC_LAT; i++) inflight = inflight + IW'(tag_vld[i]);
  end

  // Every issued op owns a FIFO slot from issue until pop, so the FIFO cannot overflow.
  assign occ    = OW'(fifo_count) + OW'(inflight);
  assign credit = (occ < DEPTH_OCC);
  assign issue  = rst_n && found && credit;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[win] = 1'b1;
  end

  assign mac_spikes = issue ? req_spikes[win] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (issue) begin
      ptr <= (win == LAST_ID) ? '0 : win + 1'b1;
    end
  end

  // Tag shift register mirrors the MAC pipeline; bit 0 is the newest stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int i = 0; i < MAC_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld   <= {tag_vld[MAC_LAT-2:0], issue};
      tag_id[0] <= win;
      for (int i = 1; i < MAC_LAT; i++) tag_id[i] <= tag_id[i-1];
    end
  end

  spike_mac_res_fifo #(
    .DEPTH (RES_DEPTH),
    .ID_W  (ID_W)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_vld[MAC_LAT-1]),
    .push_data (mac_out),
    .push_id   (tag_id[MAC_LAT-1]),
    .pop       (res_valid && res_ready),
    .valid     (res_valid),
    .data      (res_data),
    .id        (res_id),
    .count     (fifo_count)
  );

  assign busy = (|tag_vld) || (fifo_count != '0);

endmodule

// File: tb/tb_spike_mac_scheduler.sv
// Bench for spike_mac_scheduler with a behavioural 2-cycle MAC and a queue-based reference model.
module tb_spike_mac_scheduler;
  import spike_mac_scheduler_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int RES_DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic       [NUM_REQ-1:0] req_valid;
  spike_vec_t [NUM_REQ-1:0] req_spikes;
  logic       [NUM_REQ-1:0] req_ready;
  spike_vec_t               mac_spikes;
  mac_res_t                 mac_out;
  logic                     res_valid;
  logic                     res_ready;
  mac_res_t                 res_data;
  logic [1:0]               res_id;
  logic                     busy;

  spike_mac_scheduler #(.NUM_REQ(NUM_REQ), .RES_DEPTH(RES_DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_spikes (req_spikes),
    .req_ready  (req_ready),
    .mac_spikes (mac_spikes),
    .mac_out    (mac_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Weight matrix: row0 = {1,2,3,4}, row1 = {10,20,30,40}; spike i gates column i.
  function automatic mac_res_t mac_eval(spike_vec_t s);
    mac_res_t r;
    for (int row = 0; row < OUTPUT_VEC_LEN; row++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < INPUT_VEC_LEN; i++)
        if (s[i]) acc += (i + 1) * ((row == 0) ? 1 : 10);
      r[row] = WIDTH'(acc);
    end
    return r;
  endfunction

  mac_res_t mac_s1, mac_s2;
  always @(posedge clk) begin
    if (!rst_n) begin
      mac_s1 <= '0;
      mac_s2 <= '0;
    end else begin
      mac_s1 <= mac_eval(mac_spikes);
      mac_s2 <= mac_s1;
    end
  end
  assign mac_out = mac_s2;

  typedef struct { int id; mac_res_t data; int rdy; } ent_t;
  ent_t m_q[$];
  int   m_ptr = 0;
  int   cyc = 0;

  logic [3:0] exp_ready;
  spike_vec_t exp_spk;
  logic       exp_issue, exp_rv, exp_busy;
  mac_res_t   exp_data;
  int         exp_id, exp_win;

  logic [3:0] obs_ready;
  spike_vec_t obs_spk;
  logic       obs_rv, obs_busy;
  mac_res_t   obs_data;
  logic [1:0] obs_id;

  int errors = 0;
  int checks = 0;

  // Outstanding ops = issued minus popped, counted at the start of the cycle.
  task automatic model_expect();
    exp_issue = 1'b0; exp_win = 0; exp_ready = '0; exp_spk = '0;
    if (rst_n === 1'b1 && m_q.size() < RES_DEPTH) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int c;
        c = (m_ptr + i) % NUM_REQ;
        if (!exp_issue && req_valid[c]) begin
          exp_issue = 1'b1;
          exp_win   = c;
        end
      end
    end
    if (exp_issue) begin
      exp_ready = 4'(1 << exp_win);
      exp_spk   = req_spikes[exp_win];
    end
    exp_rv   = (m_q.size() > 0) && (m_q[0].rdy <= cyc);
    exp_data = exp_rv ? m_q[0].data : '0;
    exp_id   = exp_rv ? m_q[0].id : 0;
    exp_busy = (m_q.size() != 0);
  endtask

  task automatic model_commit();
    if (rst_n !== 1'b1) begin
      m_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_rv && res_ready) void'(m_q.pop_front());
      if (exp_issue) begin
        m_q.push_back('{id: exp_win, data: mac_eval(exp_spk), rdy: cyc + 3});
        m_ptr = (exp_win + 1) % NUM_REQ;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_expect();
    obs_ready = req_ready; obs_spk = mac_spikes; obs_rv = res_valid;
    obs_data = res_data; obs_id = res_id; obs_busy = busy;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic randomize_spikes();
    for (int i = 0; i < NUM_REQ; i++) req_spikes[i] = spike_vec_t'($urandom);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0;
    randomize_spikes();
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; res_ready = 1'b1;
    randomize_spikes();
    step(); step();
    checks++; if (obs_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b want 0000", obs_ready); end
    checks++; if (obs_spk !== 4'h0) begin errors++; $display("FAIL reset_mac_spikes: got %b want 0000", obs_spk); end
    rst_n = 1'b1; req_valid = '0;
    step();
    checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", obs_rv); end
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
    checks++; if (obs_data !== '0) begin errors++; $display("FAIL reset_res_data: got %h want 0", obs_data); end
    checks++; if (obs_id !== 2'd0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", obs_id); end
  endtask

  task automatic test_single_op();
    mac_res_t want;
    int lat;
    want[1] = 8'd40; want[0] = 8'd4;
    res_ready = 1'b1; req_valid = 4'b0010; req_spikes[1] = 4'b0101;
    step();
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", obs_ready); end
    checks++; if (obs_spk !== 4'b0101) begin errors++; $display("FAIL single_mac_spikes: got %b want 0101", obs_spk); end
    req_valid = '0;
    lat = 0;
    do begin step(); lat++; end while (!obs_rv && lat < 10);
    checks++; if (lat != 3) begin errors++; $display("FAIL single_latency: got %0d want 3", lat); end
    checks++; if (obs_data !== want) begin errors++; $display("FAIL single_data: got %h want %h", obs_data, want); end
    checks++; if (obs_id !== 2'd1) begin errors++; $display("FAIL single_id: got %0d want 1", obs_id); end
  endtask

  task automatic test_rr_fairness();
    int got, gap;
    apply_reset();
    res_ready = 1'b1; got = 0; gap = 0;
    for (int n = 0; n < 20 && got < 8; n++) begin
      req_valid = (n < 8) ? 4'hF : 4'h0;
      randomize_spikes();
      step();
      if (n < 8) begin
        checks++;
        if (obs_ready !== 4'(1 << (n % 4))) begin
          errors++; $display("FAIL rr_grant[%0d]: got %b want %b", n, obs_ready, 4'(1 << (n % 4)));
        end
      end
      if (obs_rv) begin
        checks++; if (obs_id !== 2'(got % 4)) begin errors++; $display("FAIL rr_res_id[%0d]: got %0d want %0d", got, obs_id, got % 4); end
        checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rr_res_data[%0d]: got %h want %h", got, obs_data, exp_data); end
        got++;
      end else if (got > 0) gap++;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL rr_result_count: got %0d want 8", got); end
    checks++; if (gap != 0) begin errors++; $display("FAIL rr_gaps: got %0d want 0", gap); end
  endtask

  task automatic test_backpressure();
    int grants, got, resumed;
    apply_reset();
    res_ready = 1'b0; req_valid = 4'hF; grants = 0;
    for (int n = 0; n < 8; n++) begin
      randomize_spikes();
      step();
      if (obs_ready != 4'h0) grants++;
    end
    checks++; if (grants != 4) begin errors++; $display("FAIL bp_issue_count: got %0d want 4", grants); end
    checks++; if (obs_ready !== 4'h0) begin errors++; $display("FAIL bp_stalled_ready: got %b want 0000", obs_ready); end
    checks++; if (obs_rv !== 1'b1 || obs_busy !== 1'b1) begin errors++; $display("FAIL bp_full_flags: got rv=%b busy=%b want 1 1", obs_rv, obs_busy); end
    res_ready = 1'b1; got = 0; resumed = 0;
    for (int n = 0; n < 6; n++) begin
      randomize_spikes();
      step();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL bp_release_grant[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      if (obs_ready != 4'h0) resumed++;
      if (obs_rv) begin
        checks++; if (obs_id !== 2'(got % 4)) begin errors++; $display("FAIL bp_drain_id[%0d]: got %0d want %0d", got, obs_id, got % 4); end
        got++;
      end
    end
    checks++; if (got != 6) begin errors++; $display("FAIL bp_drain_count: got %0d want 6", got); end
    checks++; if (resumed == 0) begin errors++; $display("FAIL bp_resume: got 0 grants want >0"); end
    req_valid = '0;
    for (int n = 0; n < 10; n++) step();
  endtask

  task automatic test_push_pop();
    int got;
    apply_reset();
    res_ready = 1'b0; req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin randomize_spikes(); step(); end
    checks++; if (obs_ready !== 4'h0) begin errors++; $display("FAIL pp_full_ready: got %b want 0000", obs_ready); end
    res_ready = 1'b1;
    step();
    checks++; if (obs_ready !== 4'h0) begin errors++; $display("FAIL pp_pop_no_credit: got %b want 0000", obs_ready); end
    checks++; if (obs_rv !== 1'b1 || obs_id !== 2'd0) begin errors++; $display("FAIL pp_first_pop: got rv=%b id=%0d want 1 0", obs_rv, obs_id); end
    got = obs_rv ? 1 : 0;
    step();
    checks++; if (obs_ready !== 4'b0001) begin errors++; $display("FAIL pp_credit_back: got %b want 0001", obs_ready); end
    req_valid = '0;
    for (int n = 0; n < 15 && got < 5; n++) begin
      if (n > 0) step();
      if (obs_rv) begin
        checks++; if (obs_id !== 2'(got % 4) || obs_data !== exp_data) begin
          errors++; $display("FAIL pp_result[%0d]: got id=%0d data=%h want id=%0d data=%h", got, obs_id, obs_data, got % 4, exp_data);
        end
        got++;
      end
    end
    checks++; if (got != 5) begin errors++; $display("FAIL pp_result_count: got %0d want 5", got); end
    step();
    checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL pp_idle_busy: got %b want 0", obs_busy); end
  endtask

  task automatic test_zero_vector();
    int lat;
    res_ready = 1'b1; req_valid = 4'b0100; req_spikes[2] = 4'b0000;
    step();
    checks++; if (obs_ready !== 4'b0100) begin errors++; $display("FAIL zero_grant: got %b want 0100", obs_ready); end
    req_valid = '0; lat = 0;
    do begin step(); lat++; end while (!obs_rv && lat < 10);
    checks++; if (obs_rv !== 1'b1) begin errors++; $display("FAIL zero_result_timeout: got rv=%b want 1", obs_rv); end
    checks++; if (obs_data !== '0 || obs_id !== 2'd2) begin errors++; $display("FAIL zero_result: got data=%h id=%0d want 0 2", obs_data, obs_id); end
  endtask

  task automatic test_reset_midop();
    int stale, lat;
    spike_vec_t s1;
    mac_res_t want;
    apply_reset();
    res_ready = 1'b0; req_valid = 4'hF;
    for (int n = 0; n < 4; n++) begin randomize_spikes(); step(); end
    rst_n = 1'b0; req_valid = '0;
    step();
    checks++; if (obs_busy !== 1'b1) begin errors++; $display("FAIL midop_busy_before: got %b want 1", obs_busy); end
    rst_n = 1'b1;
    step();
    checks++; if (obs_rv !== 1'b0 || obs_busy !== 1'b0) begin errors++; $display("FAIL midop_flush: got rv=%b busy=%b want 0 0", obs_rv, obs_busy); end
    res_ready = 1'b1; stale = 0;
    for (int n = 0; n < 5; n++) begin step(); if (obs_rv) stale++; end
    checks++; if (stale != 0) begin errors++; $display("FAIL midop_stale_results: got %0d want 0", stale); end
    randomize_spikes();
    s1 = req_spikes[1];
    want = mac_eval(s1);
    req_valid = 4'b1010;
    step();
    checks++; if (obs_ready !== 4'b0010) begin errors++; $display("FAIL midop_ptr_restart: got %b want 0010", obs_ready); end
    req_valid = '0; lat = 0;
    do begin step(); lat++; end while (!obs_rv && lat < 10);
    checks++; if (obs_rv !== 1'b1 || obs_id !== 2'd1 || obs_data !== want) begin
      errors++; $display("FAIL midop_next_op: got rv=%b id=%0d data=%h want 1 1 %h", obs_rv, obs_id, obs_data, want);
    end
  endtask

  task automatic test_random_traffic();
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      randomize_spikes();
      res_ready = ($urandom_range(0, 3) != 0);
      step();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_grant[%0d]: got %b want %b", n, obs_ready, exp_ready); end
      checks++; if (obs_spk !== exp_spk) begin errors++; $display("FAIL rnd_mac_spikes[%0d]: got %b want %b", n, obs_spk, exp_spk); end
      checks++; if (obs_rv !== exp_rv) begin errors++; $display("FAIL rnd_res_valid[%0d]: got %b want %b", n, obs_rv, exp_rv); end
      checks++; if (obs_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", n, obs_busy, exp_busy); end
      if (exp_rv) begin
        checks++; if (obs_data !== exp_data || obs_id !== 2'(exp_id)) begin
          errors++; $display("FAIL rnd_result[%0d]: got data=%h id=%0d want data=%h id=%0d", n, obs_data, obs_id, exp_data, exp_id);
        end
      end
    end
    req_valid = '0; res_ready = 1'b1;
    for (int n = 0; n < 12; n++) step();
    checks++; if (obs_busy !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("FAIL rnd_drain: got busy=%b rv=%b want 0 0", obs_busy, obs_rv); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b0; req_spikes = '0;
    test_reset();
    test_single_op();
    test_rr_fairness();
    test_backpressure();
    test_push_pop();
    test_zero_vector();
    test_reset_midop();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
